// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the fetch front end: opcode constants,
// the canonical NOP encoding and the fetch state enumeration.
package rv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO with flush, used for the instruction buffer and the PC tag queue.
// Occupancy is exported; a push on a full FIFO succeeds only together with a pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop & (count_r != {CW{1'b0}});
  assign do_push_s = push & ((count_r != FULL_CNT) | do_pop_s);

  // Pointers and occupancy; flush empties the queue regardless of push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= push_data;
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: PC, in-order imem requests, response buffer and decode handshake.
// Optional IFETCH_MISALIGN_TRAP_EN halts fetch and raises fetch_fault on a misaligned redirect.
module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  fetch_state_e  state_r;
  fetch_state_e  state_nxt_s;
  logic [31:0]   pc_r;
  logic [CW-1:0] drop_cnt_r;
  logic [CW-1:0] drop_nxt_s;
  logic [CW-1:0] tag_count_s;
  logic [CW-1:0] buf_count_s;
  logic [CW-1:0] outstanding_s;
  logic [CW-1:0] outstanding_nxt_s;
  logic [CW:0]   pipe_load_s;
  logic [31:0]   tag_head_s;
  logic [63:0]   buf_head_s;
  logic          req_fire_s;
  logic          rsp_keep_s;
  logic          rsp_drop_s;
  logic          misalign_s;

  // Dropped requests hold no tag, so in-flight = tagged + still-to-drop
  assign outstanding_s     = tag_count_s + drop_cnt_r;
  assign outstanding_nxt_s = outstanding_s + CW'(req_fire_s) - CW'(imem_rsp_valid);
  assign pipe_load_s       = {1'b0, outstanding_s} + {1'b0, buf_count_s};
  assign req_fire_s        = imem_req_valid & imem_req_ready;
  assign rsp_drop_s        = imem_rsp_valid & (drop_cnt_r != {CW{1'b0}});
  assign rsp_keep_s        = imem_rsp_valid & (drop_cnt_r == {CW{1'b0}});

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign misalign_s = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire_s & ~redirect_valid),
    .push_data (pc_r),
    .pop       (rsp_keep_s),
    .head      (tag_head_s),
    .count     (tag_count_s)
  );

  fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep_s & ~redirect_valid & (state_r != HALT)),
    .push_data ({tag_head_s, imem_rsp_data}),
    .pop       (id_valid & id_ready),
    .head      (buf_head_s),
    .count     (buf_count_s)
  );

  // State, PC and drop counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RUN;
      pc_r       <= RESET_PC;
      drop_cnt_r <= {CW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      drop_cnt_r <= drop_nxt_s;
      if (redirect_valid) pc_r <= redirect_pc & 32'hFFFF_FFFC;
      else if (req_fire_s) pc_r <= pc_r + 32'd4;
      else pc_r <= pc_r;
    end
  end

  // Next drop count and next state
  always_comb begin
    drop_nxt_s  = drop_cnt_r;
    state_nxt_s = state_r;
    if (redirect_valid) drop_nxt_s = outstanding_nxt_s;
    else if (rsp_drop_s) drop_nxt_s = drop_cnt_r - CW'(1);
    else drop_nxt_s = drop_cnt_r;
    case (state_r)
      HALT: state_nxt_s = HALT;
      RUN, DRAIN: begin
        if (misalign_s) state_nxt_s = HALT;
        else if (drop_nxt_s != {CW{1'b0}}) state_nxt_s = DRAIN;
        else state_nxt_s = RUN;
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Handshake outputs; decode fields read as zero while nothing is presented
  always_comb begin
    imem_req_valid = 1'b0;
    id_valid       = 1'b0;
    if (rst) begin
      imem_req_valid = 1'b0;
      id_valid       = 1'b0;
    end else begin
      imem_req_valid = (state_r != HALT) && (pipe_load_s < DEPTH_W);
      id_valid       = (state_r != HALT) && (buf_count_s != {CW{1'b0}});
    end
    imem_req_addr = pc_r;
    id_instr  = id_valid ? buf_head_s[31:0]  : 32'h0000_0000;
    id_pc     = id_valid ? buf_head_s[63:32] : 32'h0000_0000;
    id_opcode = id_instr[6:0];
    id_funct3 = id_instr[14:12];
    id_funct7 = id_instr[31:25];
`ifdef IFETCH_MISALIGN_TRAP_EN
    fetch_fault = (state_r == HALT);
`endif
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized phase,
// all checked against a transaction-level model of imem, buffer occupancy and PC order.
module tb_instr_fetch;
  import rv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc;
  logic redirect_valid, id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [6:0] id_opcode, id_funct7;
  logic [2:0] id_funct3;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic fetch_fault;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7)
`ifdef IFETCH_MISALIGN_TRAP_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  typedef struct { logic [31:0] addr; int cyc; int ep; } req_t;
  req_t pend[$];              // accepted requests awaiting response
  logic [31:0] buf_q[$];      // PCs buffered for decode
  logic [31:0] exp_req_addr;
  int epoch = 0, cyc_cnt = 0, halted = 0, req_fires = 0;
  logic [31:0] last_req_addr;
  int errors = 0, checks = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h4000_0033;
    else if (a == 32'h0000_0204) return 32'h0000_0013;
    else return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic idr, input logic rqr, input logic rsp_en,
                       input logic redir, input logic [31:0] tgt);
    logic exp_rv, exp_idv;
    logic [31:0] w;
    req_t r;
    @(negedge clk);
    cyc_cnt++;
    id_ready = idr; imem_req_ready = rqr; redirect_valid = redir; redirect_pc = tgt;
    if (rsp_en && pend.size() > 0 && pend[0].cyc < cyc_cnt) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    end
    #1;
    exp_rv  = (halted == 0) && (pend.size() + buf_q.size() < DEPTH);
    exp_idv = (buf_q.size() > 0);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    chk("id_valid", {31'b0, id_valid}, {31'b0, exp_idv});
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("fault", {31'b0, fetch_fault}, (halted != 0) ? 32'd1 : 32'd0);
`endif
    if (exp_idv) begin
      w = mem(buf_q[0]);
      chk("id_pc", id_pc, buf_q[0]);
      chk("id_instr", id_instr, w);
      chk("id_fields", {15'b0, id_funct7, id_funct3, id_opcode}, {15'b0, w[31:25], w[14:12], w[6:0]});
    end else begin
      chk("id_idle", id_instr | id_pc, 32'h0);
    end
    if (id_valid && idr && buf_q.size() > 0) void'(buf_q.pop_front());
    if (imem_rsp_valid) begin
      r = pend.pop_front();
      if (r.ep == epoch && !redir && halted == 0) buf_q.push_back(r.addr);
    end
    if (imem_req_valid && rqr) begin
      chk("req_addr", imem_req_addr, exp_req_addr);
      pend.push_back('{exp_req_addr, cyc_cnt, epoch});
      req_fires++; last_req_addr = imem_req_addr;
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (redir) begin
      epoch++; buf_q.delete();
      exp_req_addr = tgt & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) halted = 1;
`endif
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); #2;
    rst = 1'b1;
    id_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    pend.delete(); buf_q.delete(); exp_req_addr = RESET_PC; halted = 0; epoch++;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_hold", {30'b0, imem_req_valid, id_valid}, 32'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    int seen, hit, n0;
    logic [31:0] t;
    // T1: reset then free-running fetch
    do_reset(3);
    #1;
    chk("t1_first_addr", imem_req_addr, RESET_PC);
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    // T2: decode stall fills the buffer, no more than DEPTH requests
    do_reset(2);
    n0 = req_fires;
    repeat (10) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t2_req_count", req_fires - n0, 32'd2);
    #1 chk("t2_head", id_pc, 32'h0000_0000);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #1 chk("t2_second", id_pc, 32'h0000_0004);
    n0 = req_fires;
    for (int i = 0; i < 10 && req_fires == n0; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t2_resume", last_req_addr, 32'h0000_0008);
    // T3: redirect with two requests in flight
    for (int i = 0; i < 20 && pend.size() != 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t3_two_outstanding", pend.size(), 32'd2);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      #1 if (id_valid) seen = 1;
    end
    chk("t3_seen", seen, 32'd1);
    chk("t3_target", id_pc, 32'h0000_0100);
    // T5: decoder field extraction
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      #1 if (id_valid) seen = 1;
    end
    chk("t5_pc", id_pc, 32'h0000_0200);
    chk("t5_opcode", {25'b0, id_opcode}, {25'b0, OPC_R});
    chk("t5_funct3", {29'b0, id_funct3}, 32'd0);
    chk("t5_funct7", {25'b0, id_funct7}, {25'b0, 7'b0100000});
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #1 chk("t5_next_pc", id_pc, 32'h0000_0204);
    chk("t5_nop_opcode", {25'b0, id_opcode}, {25'b0, OPC_I});
    chk("t5_nop_word", id_instr, NOP_INSTR);
    // T4: redirect together with a decode handshake and a request acceptance
    hit = 0;
    for (int i = 0; i < 30 && hit == 0; i++) begin
      if (buf_q.size() > 0 && pend.size() + buf_q.size() < DEPTH) begin
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
        hit = 1;
      end else cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("t4_hit", hit, 32'd1);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      #1 if (id_valid) seen = 1;
    end
    chk("t4_target", id_pc, 32'h0000_0300);
    // Randomized traffic with occasional redirects
    repeat (1500) begin
      t = $urandom & 32'h0000_0FFF;
`ifdef IFETCH_MISALIGN_TRAP_EN
      t = t & 32'hFFFF_FFFC;
`endif
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 39) == 0), t);
    end
    // T6: reset while the buffer is full
    for (int i = 0; i < 20 && buf_q.size() != DEPTH; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_full", buf_q.size(), DEPTH);
    do_reset(3);
    #1;
    chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t6_addr", imem_req_addr, RESET_PC);
    repeat (8) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0102);
    n0 = req_fires;
    repeat (20) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_halt_no_req", req_fires - n0, 32'd0);
    chk("t6_fault", {31'b0, fetch_fault}, 32'd1);
`else
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0102);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      #1 if (id_valid) seen = 1;
    end
    chk("t6_masked_pc", id_pc, 32'h0000_0100);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
